// File: rtl/ms_pkg.sv
// Shared defaults and helpers for the multi-stream input demultiplexer.
package ms_pkg;

  // Default payload width of every flow.
  localparam int MS_DATA_W = 8;
  // Default number of flows.
  localparam int MS_FLUX   = 2;
  // Default per-flow FIFO depth (power of two).
  localparam int MS_DEPTH  = 16;

  // Width of the flow tag carried in the MSBs of the input word.
  // A single flow still gets one tag bit, so the word format never collapses.
  function automatic int tag_width(input int flux);
    return (flux > 1) ? $clog2(flux) : 1;
  endfunction

endpackage

// File: rtl/ms_flow_fifo.sv
// First-word-fall-through FIFO for one flow. The head word, full and empty
// are all registered and computed from the post-edge pointer values, so the
// head of a freshly written word is visible one cycle after the write.
// Pointers carry one extra wrap bit: equal pointers mean empty, equal low bits
// with differing wrap bits mean full.
module ms_flow_fifo
  import ms_pkg::*;
#(
  parameter int DATA_W = MS_DATA_W,
  parameter int DEPTH  = MS_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW:0]       wr_ptr_reg, wr_ptr_next;
  logic [AW:0]       rd_ptr_reg, rd_ptr_next;
  logic              full_reg, full_next;
  logic              empty_reg, empty_next;
  logic [DATA_W-1:0] dout_reg, dout_next;
  logic              wr_acc;
  logic              rd_acc;

  // A write into a full FIFO is dropped even if a read frees a slot this cycle;
  // a read of an empty FIFO is ignored even if a write fills it this cycle.
  assign wr_acc = wr_en && !full_reg;
  assign rd_acc = rd_en && !empty_reg;

  // Next pointers, flags and head word as they will stand after this edge.
  always_comb begin
    wr_ptr_next = wr_ptr_reg + (AW + 1)'(wr_acc);
    rd_ptr_next = rd_ptr_reg + (AW + 1)'(rd_acc);
    empty_next  = (wr_ptr_next == rd_ptr_next);
    full_next   = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                  (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
    dout_next   = dout_reg;
    if (!empty_next) begin
      // The new head is the word being written right now when it lands
      // exactly in the slot the read pointer will point at.
      if (wr_acc && (rd_ptr_next == wr_ptr_reg)) begin
        dout_next = wr_data;
      end else begin
        dout_next = mem[rd_ptr_next[AW-1:0]];
      end
    end
  end

  // Storage array; no reset so it maps onto block or distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  // Pointer, flag and head registers; reset discards all buffered words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      dout_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      full_reg   <= full_next;
      empty_reg  <= empty_next;
      dout_reg   <= dout_next;
    end
  end

  assign rd_data = dout_reg;
  assign full    = full_reg;
  assign empty   = empty_reg;

endmodule

// File: rtl/ms_input_demux.sv
// Input demultiplexer: one tagged write stream is split into FLUX independent
// FWFT FIFOs selected by the tag in the MSBs of din. Writes with an
// out-of-range tag or aimed at a full flow are dropped without side effects.
// Optional feature: define MS_DEMUX_ERR_EN to add a sticky err output that
// latches on any dropped write until reset.
module ms_input_demux
  import ms_pkg::*;
#(
  parameter  int DATA_W = MS_DATA_W,
  parameter  int FLUX   = MS_FLUX,
  parameter  int DEPTH  = MS_DEPTH,
  localparam int TAG_W  = tag_width(FLUX)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W+TAG_W-1:0]      din,
  input  logic                         write,
  output logic [FLUX-1:0]              full,
  input  logic [FLUX-1:0]              rd,
  output logic [FLUX-1:0][DATA_W-1:0]  dout,
  output logic [FLUX-1:0]              empty
`ifdef MS_DEMUX_ERR_EN
  ,
  output logic                         err
`endif
);

  logic [TAG_W-1:0]  tag;
  logic [DATA_W-1:0] payload;
  logic [FLUX-1:0]   wr_en;

  assign tag     = din[DATA_W+TAG_W-1:DATA_W];
  assign payload = din[DATA_W-1:0];

  // One steering term and one FIFO per flow. A tag that matches no flow index
  // enables nothing, so out-of-range tags are dropped by construction.
  generate
    for (genvar gi = 0; gi < FLUX; gi++) begin : g_flow
      assign wr_en[gi] = write && (tag == TAG_W'(gi)) && !full[gi];

      ms_flow_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en[gi]),
        .wr_data (payload),
        .rd_en   (rd[gi]),
        .rd_data (dout[gi]),
        .full    (full[gi]),
        .empty   (empty[gi])
      );
    end
  endgenerate

`ifdef MS_DEMUX_ERR_EN
  logic drop;
  logic err_reg;

  // A write that reaches no FIFO is a protocol error.
  assign drop = write && !(|wr_en);

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_reg <= 1'b0;
    end else if (drop) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`endif

endmodule

// File: tb/tb_ms_input_demux.sv
// Scoreboard bench for ms_input_demux (three flows, so an out-of-range tag
// exists). Stimulus pushes expected payloads per flow; a negedge monitor pops
// and compares whenever a read of a non-empty flow is presented.
module tb_ms_input_demux;
  import ms_pkg::*;

  localparam int DATA_W = 8;
  localparam int FLUX   = 3;
  localparam int DEPTH  = 16;
  localparam int TAG_W  = 2;

  logic                        clk = 1'b0;
  logic                        rst = 1'b0;
  logic [DATA_W+TAG_W-1:0]     din = '0;
  logic                        write = 1'b0;
  logic [FLUX-1:0]             full;
  logic [FLUX-1:0]             rd = '0;
  logic [FLUX-1:0][DATA_W-1:0] dout;
  logic [FLUX-1:0]             empty;
`ifdef MS_DEMUX_ERR_EN
  logic                        err;
`endif

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] exp_q [FLUX][$];
  int                occ [FLUX];
  bit                err_exp;

  ms_input_demux #(
    .DATA_W (DATA_W),
    .FLUX   (FLUX),
    .DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .write (write),
    .full  (full),
    .rd    (rd),
    .dout  (dout),
    .empty (empty)
`ifdef MS_DEMUX_ERR_EN
    ,
    .err   (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: every presented read of a non-empty flow must return the oldest
  // expected word of that flow.
  always @(negedge clk) begin
    logic [DATA_W-1:0] e;
    if (rst) begin
      for (int f = 0; f < FLUX; f++) begin
        if (rd[f] && !empty[f]) begin
          if (exp_q[f].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_f%0d: got %02h expected no word", f, dout[f]);
          end else begin
            e = exp_q[f].pop_front();
            $display("read  flow=%0d data=%02h", f, dout[f]);
            check($sformatf("dout_f%0d", f), 32'(dout[f]), 32'(e));
          end
        end
      end
    end
  end

  task automatic check_flags();
    for (int f = 0; f < FLUX; f++) begin
      check($sformatf("empty_f%0d", f), 32'(empty[f]), 32'(occ[f] == 0));
      check($sformatf("full_f%0d", f), 32'(full[f]), 32'(occ[f] == DEPTH));
    end
`ifdef MS_DEMUX_ERR_EN
    check("err", 32'(err), 32'(err_exp));
`endif
  endtask

  // One clock cycle of stimulus; called and returns 1 time unit after a posedge.
  task automatic cycle(input bit w, input int tag, input logic [DATA_W-1:0] pl,
                       input logic [FLUX-1:0] rdv);
    bit acc;
    write = w;
    din   = {TAG_W'(tag), pl};
    rd    = rdv;
    acc   = w && (tag < FLUX) && (occ[tag] < DEPTH);
    if (acc) exp_q[tag].push_back(pl);
    if (w && !acc) err_exp = 1'b1;
    if (w) $display("write flow=%0d data=%02h %s", tag, pl, acc ? "accepted" : "dropped");
    @(posedge clk);
    for (int f = 0; f < FLUX; f++) begin
      if (rdv[f] && occ[f] > 0) occ[f]--;
    end
    if (acc) occ[tag]++;
    #1;
    write = 1'b0;
    rd    = '0;
    check_flags();
  endtask

  function automatic logic [FLUX-1:0] nonempty_mask();
    logic [FLUX-1:0] m;
    for (int f = 0; f < FLUX; f++) m[f] = (occ[f] > 0);
    return m;
  endfunction

  task automatic drain();
    for (int n = 0; n < 2 * DEPTH * FLUX && nonempty_mask() != '0; n++) begin
      cycle(1'b0, 0, '0, nonempty_mask());
    end
  endtask

  // Reset asserted in the middle of a cycle; state must clear immediately.
  task automatic apply_reset();
    #1;
    rst = 1'b0;
    #1;
    check("rst_empty", 32'(empty), 32'({FLUX{1'b1}}));
    check("rst_full", 32'(full), 32'(0));
    for (int f = 0; f < FLUX; f++) check($sformatf("rst_dout_f%0d", f), 32'(dout[f]), 32'(0));
`ifdef MS_DEMUX_ERR_EN
    check("rst_err", 32'(err), 32'(0));
`endif
    for (int f = 0; f < FLUX; f++) begin
      exp_q[f].delete();
      occ[f] = 0;
    end
    err_exp = 1'b0;
    $display("reset asserted");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int f = 0; f < FLUX; f++) occ[f] = 0;
    err_exp = 1'b0;
    @(posedge clk);
    #1;
    apply_reset();

    // Interleaved writes to two flows; heads fall through one cycle later.
    cycle(1'b1, 0, 8'h11, '0);
    cycle(1'b1, 1, 8'h22, '0);
    check("fwft_f0", 32'(dout[0]), 32'h11);
    check("fwft_f1", 32'(dout[1]), 32'h22);
    cycle(1'b1, 0, 8'h33, '0);
    cycle(1'b1, 1, 8'h44, '0);
    cycle(1'b0, 0, '0, 3'b011);
    check("head2_f0", 32'(dout[0]), 32'h33);
    check("head2_f1", 32'(dout[1]), 32'h44);
    cycle(1'b0, 0, '0, 3'b011);

    // Fill flow 0, then one more write that must be dropped.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 0, 8'(8'h80 + i), '0);
    check("fill_full_f0", 32'(full[0]), 32'h1);
    check("fill_full_f1", 32'(full[1]), 32'h0);
    cycle(1'b1, 0, 8'hAA, '0);
    drain();

    // Full flow 1: write plus read in the same cycle drops the write.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1, 8'(8'hC0 + i), '0);
    cycle(1'b1, 1, 8'hBB, 3'b010);
    check("full_rd_f1", 32'(full[1]), 32'h0);
    drain();

    // Empty flow 0: read is ignored, write lands and falls through.
    cycle(1'b1, 0, 8'h5A, 3'b001);
    check("wr_rd_empty_e0", 32'(empty[0]), 32'h0);
    check("wr_rd_empty_d0", 32'(dout[0]), 32'h5A);
    drain();

    // Out-of-range tag and the highest legal tag.
    cycle(1'b1, 3, 8'h77, '0);
    cycle(1'b1, 2, 8'h99, '0);
    check("tag2_d2", 32'(dout[2]), 32'h99);
    drain();

    // Reset mid-stream with eight words buffered, then wrap traffic.
    for (int i = 0; i < 8; i++) cycle(1'b1, 0, 8'(i + 1), '0);
    apply_reset();
    for (int i = 0; i < 40; i++) cycle(1'b1, i % FLUX, 8'(i * 7 + 3), nonempty_mask());
    drain();

    for (int f = 0; f < FLUX; f++) check($sformatf("left_f%0d", f), 32'(exp_q[f].size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
